// File: rtl/aes_gcm_frame_tx.sv
// Builds the AES-GCM core input frame (key, header, IV, AAD, data) from one command and a payload stream.
// Command accepted in cycle N presents KEY_HI in N+1; output register holds until out_ready, one word/cycle when drained.
module aes_gcm_frame_tx #(
    parameter int DW            = 128,
    parameter int MAX_AAD_BYTES = 8191
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [255:0]  cmd_key,
    input  logic [127:0]  cmd_iv,
    input  logic [7:0]    cmd_iv_bits,
    input  logic [12:0]   cmd_aad_bytes,
    input  logic [28:0]   cmd_data_bytes,
    output logic          cmd_err,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_sof,
    output logic          out_last,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_KEY_HI, S_KEY_LO, S_HDR, S_IV, S_AAD, S_DATA
    } state_t;

    state_t        state, state_nxt;
    logic          out_valid_nxt, out_sof_nxt, out_last_nxt, cmd_err_nxt;
    logic [127:0]  out_data_nxt;
    logic [25:0]   cnt_q, cnt_nxt;
    logic          cap;
    logic          drain;

    // Per-frame fields captured at command accept
    logic [127:0]  key_lo_q, hdr_q, iv_q;
    logic [9:0]    aad_blks_q;
    logic [25:0]   data_blks_q;
    logic [3:0]    aad_rem_q, data_rem_q;

    logic [9:0]    cmd_aad_blks;
    logic [25:0]   cmd_data_blks;
    logic [127:0]  cmd_hdr, cmd_iv_mask;
    logic          cmd_bad;
    logic [3:0]    phase_rem;

    function automatic logic [127:0] keep_mask(input logic [3:0] rem);
        // Keep the top rem bytes; a zero remainder means the word is full.
        if (rem == 4'd0) keep_mask = {128{1'b1}};
        else             keep_mask = ~({128{1'b1}} >> {rem, 3'b000});
    endfunction

    assign cmd_aad_blks  = {1'b0, cmd_aad_bytes[12:4]} + 10'(|cmd_aad_bytes[3:0]);
    assign cmd_data_blks = {1'b0, cmd_data_bytes[28:4]} + 26'(|cmd_data_bytes[3:0]);

    assign cmd_hdr = {32'h0, {cmd_data_bytes, 3'b000}, {6'b0, cmd_aad_blks}, 16'h0001,
                      {cmd_aad_bytes, 3'b000}, {8'h00, cmd_iv_bits}};

    assign cmd_iv_mask = (cmd_iv_bits == 8'h80) ? {128{1'b1}} : ~({128{1'b1}} << cmd_iv_bits);

    assign cmd_bad = (cmd_iv_bits == 8'h00) || (cmd_iv_bits[2:0] != 3'b000) ||
                     (cmd_iv_bits > 8'h80) ||
                     (int'({19'd0, cmd_aad_bytes}) > MAX_AAD_BYTES);

    assign drain     = out_valid && out_ready;
    assign phase_rem = (state == S_DATA) ? data_rem_q : aad_rem_q;
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_nxt     = state;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        out_sof_nxt   = out_sof;
        out_last_nxt  = out_last;
        cmd_err_nxt   = 1'b0;
        cnt_nxt       = cnt_q;
        cap           = 1'b0;
        in_ready      = 1'b0;

        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_bad) begin
                        cmd_err_nxt = 1'b1;
                    end else begin
                        cap           = 1'b1;
                        out_valid_nxt = 1'b1;
                        out_data_nxt  = cmd_key[255:128];
                        out_sof_nxt   = 1'b1;
                        out_last_nxt  = 1'b0;
                        state_nxt     = S_KEY_HI;
                    end
                end
            end
            S_KEY_HI: begin
                if (drain) begin
                    out_data_nxt = key_lo_q;
                    out_sof_nxt  = 1'b0;
                    state_nxt    = S_KEY_LO;
                end
            end
            S_KEY_LO: begin
                if (drain) begin
                    out_data_nxt = hdr_q;
                    state_nxt    = S_HDR;
                end
            end
            S_HDR: begin
                if (drain) begin
                    out_data_nxt = iv_q;
                    out_last_nxt = (aad_blks_q == 10'd0) && (data_blks_q == 26'd0);
                    state_nxt    = S_IV;
                end
            end
            S_IV: begin
                if (drain) begin
                    out_valid_nxt = 1'b0;
                    out_last_nxt  = 1'b0;
                    if (aad_blks_q != 10'd0) begin
                        cnt_nxt   = {16'd0, aad_blks_q};
                        state_nxt = S_AAD;
                    end else if (data_blks_q != 26'd0) begin
                        cnt_nxt   = data_blks_q;
                        state_nxt = S_DATA;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_AAD, S_DATA: begin
                in_ready = (cnt_q != 26'd0) && (!out_valid || out_ready);
                if (in_valid && in_ready) begin
                    out_valid_nxt = 1'b1;
                    out_data_nxt  = in_data & ((cnt_q == 26'd1) ? keep_mask(phase_rem) : {128{1'b1}});
                    out_last_nxt  = (cnt_q == 26'd1) && ((state == S_DATA) || (data_blks_q == 26'd0));
                    cnt_nxt       = cnt_q - 26'd1;
                end else if (drain) begin
                    out_valid_nxt = 1'b0;
                    out_last_nxt  = 1'b0;
                    // Counter at zero means the phase's final word just left
                    if (cnt_q == 26'd0) begin
                        if ((state == S_AAD) && (data_blks_q != 26'd0)) begin
                            cnt_nxt   = data_blks_q;
                            state_nxt = S_DATA;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_last  <= 1'b0;
            cmd_err   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state     <= state_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            out_sof   <= out_sof_nxt;
            out_last  <= out_last_nxt;
            cmd_err   <= cmd_err_nxt;
            cnt_q     <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (cap) begin
            key_lo_q    <= cmd_key[127:0];
            hdr_q       <= cmd_hdr;
            iv_q        <= cmd_iv & cmd_iv_mask;
            aad_blks_q  <= cmd_aad_blks;
            data_blks_q <= cmd_data_blks;
            aad_rem_q   <= cmd_aad_bytes[3:0];
            data_rem_q  <= cmd_data_bytes[3:0];
        end
    end

endmodule

// File: tb/tb_aes_gcm_frame_tx.sv
// Directed bench for aes_gcm_frame_tx: frame contents, padding, backpressure, rejection, reset and back-to-back.
module tb_aes_gcm_frame_tx;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready, cmd_err;
    logic [255:0] cmd_key;
    logic [127:0] cmd_iv;
    logic [7:0]   cmd_iv_bits;
    logic [12:0]  cmd_aad_bytes;
    logic [28:0]  cmd_data_bytes;
    logic         in_valid, in_ready;
    logic [127:0] in_data;
    logic         out_valid, out_ready, out_sof, out_last, busy;
    logic [127:0] out_data;

    always #5 clk = ~clk;

    aes_gcm_frame_tx #(.DW(128), .MAX_AAD_BYTES(8191)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key), .cmd_iv(cmd_iv),
        .cmd_iv_bits(cmd_iv_bits), .cmd_aad_bytes(cmd_aad_bytes), .cmd_data_bytes(cmd_data_bytes),
        .cmd_err(cmd_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sof(out_sof), .out_last(out_last), .busy(busy)
    );

    int vec  = 0;
    int miss = 0;

    logic [127:0] pay[$];
    logic [127:0] got[$];
    logic [127:0] exp_w[$];
    bit           gsof[$], glast[$];
    bit           lat_valid, lat_sof, busy_seen, post_busy, post_cmd_ready;
    bit           stall_bad, ir_bad, timeout, cmd_rdy_seen;
    logic [127:0] lat_data;
    int           stall_cycles;

    localparam logic [127:0] P0 = 128'hd9313225f88406e5a55909c5aff5269a;
    localparam logic [127:0] P1 = 128'h86a7a9531534f7da2e4c303d8a318a72;
    localparam logic [127:0] P2 = 128'h1c3c0c95956809532fcf0e2449a6b525;
    localparam logic [127:0] P3 = 128'hb16aedf5aa0de657ba637b391aafd255;
    localparam logic [127:0] HDR0 = 128'h0000000000000000_0000000100000060;

    // Starts at a negedge; returns at the negedge after the out_last handshake.
    task automatic run_frame(input logic [255:0] key, input logic [127:0] iv, input logic [7:0] ivb,
                             input logic [12:0] aadb, input logic [28:0] datb,
                             input int stall_at, input int stall_len);
        int pidx = 0;
        int cyc = 0;
        bit done = 0;
        bit holding = 0;
        logic [127:0] held = '0;
        got.delete(); gsof.delete(); glast.delete();
        stall_bad = 0; ir_bad = 0; stall_cycles = 0;
        cmd_key = key; cmd_iv = iv; cmd_iv_bits = ivb; cmd_aad_bytes = aadb; cmd_data_bytes = datb;
        cmd_valid = 1; out_ready = 1; in_valid = 0;
        #1 cmd_rdy_seen = cmd_ready;
        @(negedge clk);
        cmd_valid = 0;
        lat_valid = out_valid; lat_sof = out_sof; lat_data = out_data; busy_seen = busy;
        while (!done && cyc < 300) begin
            if (stall_cycles < stall_len && out_valid && got.size() == stall_at) begin
                out_ready = 0;
                stall_cycles++;
            end else begin
                out_ready = 1;
            end
            in_valid = (pidx < pay.size());
            in_data  = in_valid ? pay[pidx] : '0;
            #1;
            if (holding && out_data !== held) stall_bad = 1;
            holding = out_valid && !out_ready;
            held    = out_data;
            if (out_valid && !out_ready && in_ready) ir_bad = 1;
            if (out_valid && out_ready) begin
                got.push_back(out_data); gsof.push_back(out_sof); glast.push_back(out_last);
                if (out_last) done = 1;
            end
            if (in_valid && in_ready) pidx++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 0;
        out_ready = 1;
        timeout = !done;
        post_busy = busy;
        post_cmd_ready = cmd_ready;
    endtask

    task automatic test_reset;
        rst = 1; cmd_valid = 0; in_valid = 0; out_ready = 1; in_data = '0;
        cmd_key = '0; cmd_iv = '0; cmd_iv_bits = 8'd96; cmd_aad_bytes = '0; cmd_data_bytes = '0;
        repeat (2) @(negedge clk);
        vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        vec++; if (out_data !== 128'h0) begin miss++; $display("FAIL rst_out_data: got %h want 0", out_data); end
        vec++; if (out_sof !== 1'b0) begin miss++; $display("FAIL rst_out_sof: got %b want 0", out_sof); end
        vec++; if (out_last !== 1'b0) begin miss++; $display("FAIL rst_out_last: got %b want 0", out_last); end
        vec++; if (cmd_ready !== 1'b1) begin miss++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
        vec++; if (cmd_err !== 1'b0) begin miss++; $display("FAIL rst_cmd_err: got %b want 0", cmd_err); end
        vec++; if (in_ready !== 1'b0) begin miss++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        vec++; if (busy !== 1'b0) begin miss++; $display("FAIL rst_busy: got %b want 0", busy); end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_zero_frame;
        pay.delete();
        exp_w = '{128'h0, 128'h0, HDR0, 128'h0};
        run_frame('0, '0, 8'd96, 13'd0, 29'd0, 0, 0);
        vec++; if (timeout !== 1'b0) begin miss++; $display("FAIL zero_timeout: got %b want 0", timeout); end
        vec++; if (cmd_rdy_seen !== 1'b1) begin miss++; $display("FAIL zero_cmd_ready: got %b want 1", cmd_rdy_seen); end
        vec++; if ({lat_valid, lat_sof, busy_seen} !== 3'b111) begin miss++; $display("FAIL zero_latency: got %b want 111", {lat_valid, lat_sof, busy_seen}); end
        vec++; if (got.size() !== 4) begin miss++; $display("FAIL zero_count: got %0d want 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            vec++; if (got[i] !== exp_w[i]) begin miss++; $display("FAIL zero_word%0d: got %h want %h", i, got[i], exp_w[i]); end
            vec++; if (gsof[i] !== (i == 0)) begin miss++; $display("FAIL zero_sof%0d: got %b want %b", i, gsof[i], i == 0); end
            vec++; if (glast[i] !== (i == 3)) begin miss++; $display("FAIL zero_last%0d: got %b want %b", i, glast[i], i == 3); end
        end
        vec++; if ({post_busy, post_cmd_ready} !== 2'b01) begin miss++; $display("FAIL zero_post: got busy/cmd_ready %b want 01", {post_busy, post_cmd_ready}); end
    endtask

    task automatic test_gcm128(input int stall_at, input int stall_len);
        pay = '{P0, P1, P2, P3};
        exp_w = '{128'h0, 128'hfeffe9928665731c6d6a8f9467308308, 128'h00000000000002000000000100000060,
                  128'h00000000cafebabefacedbaddecaf888, P0, P1, P2, P3};
        run_frame({128'h0, 128'hfeffe9928665731c6d6a8f9467308308}, 128'hcafebabefacedbaddecaf888,
                  8'd96, 13'd0, 29'd64, stall_at, stall_len);
        vec++; if (timeout !== 1'b0) begin miss++; $display("FAIL gcm_timeout: got %b want 0", timeout); end
        vec++; if (got.size() !== 8) begin miss++; $display("FAIL gcm_count: got %0d want 8", got.size()); end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            vec++; if (got[i] !== exp_w[i]) begin miss++; $display("FAIL gcm_word%0d: got %h want %h", i, got[i], exp_w[i]); end
            vec++; if (glast[i] !== (i == 7)) begin miss++; $display("FAIL gcm_last%0d: got %b want %b", i, glast[i], i == 7); end
        end
    endtask

    task automatic test_aad_data;
        pay = '{128'hfeedfacedeadbeeffeedfacedeadbeef, 128'habaddad2112233445566778899aabbcc,
                P0, P1, P2, P3};
        exp_w = '{128'h000102030405060708090a0b0c0d0e0f, 128'h101112131415161718191a1b1c1d1e1f,
                  128'h00000000000001e00002000100A00040, 128'h0000000000000000cafebabefacedbad,
                  128'hfeedfacedeadbeeffeedfacedeadbeef, 128'habaddad2000000000000000000000000,
                  P0, P1, P2, 128'hb16aedf5aa0de657ba637b3900000000};
        run_frame({128'h000102030405060708090a0b0c0d0e0f, 128'h101112131415161718191a1b1c1d1e1f},
                  128'hffffffffffffffffcafebabefacedbad, 8'd64, 13'd20, 29'd60, 0, 0);
        vec++; if (timeout !== 1'b0) begin miss++; $display("FAIL aad_timeout: got %b want 0", timeout); end
        vec++; if (lat_data !== exp_w[0]) begin miss++; $display("FAIL aad_key_hi_latency: got %h want %h", lat_data, exp_w[0]); end
        vec++; if (got.size() !== 10) begin miss++; $display("FAIL aad_count: got %0d want 10", got.size()); end
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            vec++; if (got[i] !== exp_w[i]) begin miss++; $display("FAIL aad_word%0d: got %h want %h", i, got[i], exp_w[i]); end
            vec++; if (glast[i] !== (i == 9)) begin miss++; $display("FAIL aad_last%0d: got %b want %b", i, glast[i], i == 9); end
        end
    endtask

    task automatic test_backpressure;
        test_gcm128(5, 5);
        vec++; if (stall_cycles !== 5) begin miss++; $display("FAIL bp_stall_cycles: got %0d want 5", stall_cycles); end
        vec++; if (stall_bad !== 1'b0) begin miss++; $display("FAIL bp_data_stable: got unstable=%b want 0", stall_bad); end
        vec++; if (ir_bad !== 1'b0) begin miss++; $display("FAIL bp_in_ready: got in_ready_seen=%b want 0", ir_bad); end
    endtask

    task automatic test_illegal;
        bit seen_valid = 0;
        cmd_key = '1; cmd_iv = '1; cmd_iv_bits = 8'd100; cmd_aad_bytes = 13'd16; cmd_data_bytes = 29'd16;
        cmd_valid = 1;
        @(negedge clk);
        cmd_valid = 0;
        vec++; if (cmd_err !== 1'b1) begin miss++; $display("FAIL ill_err_pulse: got %b want 1", cmd_err); end
        vec++; if (busy !== 1'b0) begin miss++; $display("FAIL ill_busy: got %b want 0", busy); end
        seen_valid = out_valid;
        @(negedge clk);
        vec++; if (cmd_err !== 1'b0) begin miss++; $display("FAIL ill_err_width: got %b want 0", cmd_err); end
        for (int i = 0; i < 3; i++) begin
            if (out_valid) seen_valid = 1;
            @(negedge clk);
        end
        vec++; if (seen_valid !== 1'b0) begin miss++; $display("FAIL ill_no_output: got out_valid seen=%b want 0", seen_valid); end
        pay.delete();
        run_frame('0, '0, 8'd96, 13'd0, 29'd0, 0, 0);
        vec++; if (got.size() !== 4) begin miss++; $display("FAIL ill_next_count: got %0d want 4", got.size()); end
        vec++; if (got.size() > 2 && got[2] !== HDR0) begin miss++; $display("FAIL ill_next_hdr: got %h want %h", got[2], HDR0); end
    endtask

    task automatic test_reset_mid;
        bit took = 0;
        cmd_key = '1; cmd_iv = 128'h1234; cmd_iv_bits = 8'd96; cmd_aad_bytes = 13'd48; cmd_data_bytes = 29'd16;
        cmd_valid = 1; out_ready = 1;
        @(negedge clk);
        cmd_valid = 0;
        for (int i = 0; i < 20 && !took; i++) begin
            in_valid = 1; in_data = 128'h5555;
            #1 took = in_ready;
            @(negedge clk);
        end
        in_valid = 0;
        vec++; if ({took, out_valid} !== 2'b11) begin miss++; $display("FAIL rmid_in_aad: got took/out_valid %b want 11", {took, out_valid}); end
        rst = 1;
        @(negedge clk);
        vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
        vec++; if (busy !== 1'b0) begin miss++; $display("FAIL rmid_busy: got %b want 0", busy); end
        vec++; if (cmd_ready !== 1'b1) begin miss++; $display("FAIL rmid_cmd_ready: got %b want 1", cmd_ready); end
        rst = 0;
        @(negedge clk);
        pay.delete();
        run_frame('0, '0, 8'd96, 13'd0, 29'd0, 0, 0);
        vec++; if (got.size() !== 4) begin miss++; $display("FAIL rmid_next_count: got %0d want 4", got.size()); end
        vec++; if (got.size() > 0 && {gsof[0], got[0]} !== {1'b1, 128'h0}) begin miss++; $display("FAIL rmid_next_sof: got sof=%b word=%h want sof=1 word=0", gsof[0], got[0]); end
    endtask

    task automatic test_back_to_back;
        pay.delete();
        run_frame({128'h1, 128'h2}, '0, 8'd96, 13'd0, 29'd0, 0, 0);
        vec++; if ({post_busy, post_cmd_ready} !== 2'b01) begin miss++; $display("FAIL b2b_post: got busy/cmd_ready %b want 01", {post_busy, post_cmd_ready}); end
        pay = '{128'h0f0e0d0c0b0a09080706050403020100};
        exp_w = '{128'h3, 128'h4, 128'h00000000000000000001000100800060, 128'h0,
                  128'h0f0e0d0c0b0a09080706050403020100};
        run_frame({128'h3, 128'h4}, '0, 8'd96, 13'd16, 29'd0, 0, 0);
        vec++; if (cmd_rdy_seen !== 1'b1) begin miss++; $display("FAIL b2b_accept: got %b want 1", cmd_rdy_seen); end
        vec++; if (lat_data !== 128'h3) begin miss++; $display("FAIL b2b_key_hi: got %h want 3", lat_data); end
        vec++; if (got.size() !== 5) begin miss++; $display("FAIL b2b_count: got %0d want 5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            vec++; if (got[i] !== exp_w[i]) begin miss++; $display("FAIL b2b_word%0d: got %h want %h", i, got[i], exp_w[i]); end
            vec++; if (glast[i] !== (i == 4)) begin miss++; $display("FAIL b2b_last%0d: got %b want %b", i, glast[i], i == 4); end
        end
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_gcm128(0, 0);
        test_aad_data();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
